// File: rtl/rsp_reorder_buffer.sv
// rtl/rsp_reorder_buffer.sv - restores issue order for out-of-order execution-unit responses
//
// Responses are accepted in any order and handed downstream strictly in the
// order their IDs were issued.
//
// Ports:
//   clk             single clock, all state updates on the rising edge
//   rst_b           synchronous, active-high reset
//   issue_valid     dispatcher presents an ID being sent to the execution unit
//   issue_id        ID of the issued request
//   issue_ready     buffer accepts issue_id this cycle
//   in_rsp          execution-unit response, packed as {rsp, rsp_id, rsp_data}
//   out_valid       oldest issued ID has its response stored
//   out_ready       downstream accepts the presented response
//   out_id          ID of the presented response (0 when out_valid is low)
//   out_data        data of the presented response (0 when out_valid is low)
//   outstanding_cnt issued-but-not-popped count, 0..NUM_TAGS
//   err_unexpected  one-cycle pulse, a response was dropped the cycle before
module rsp_reorder_buffer #(
  parameter int NUM_TAGS = 8,
  parameter int DATA_W   = 64
) (
  input  logic                              clk,
  input  logic                              rst_b,
  input  logic                              issue_valid,
  input  logic [$clog2(NUM_TAGS)-1:0]       issue_id,
  output logic                              issue_ready,
  input  logic [DATA_W+$clog2(NUM_TAGS):0]  in_rsp,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(NUM_TAGS)-1:0]       out_id,
  output logic [DATA_W-1:0]                 out_data,
  output logic [$clog2(NUM_TAGS):0]         outstanding_cnt,
  output logic                              err_unexpected
);

  localparam int IDW = $clog2(NUM_TAGS);
  localparam logic [IDW:0] PTR_ONE = (IDW+1)'(1);

  // Pointers carry one extra MSB as the wrap bit.
  logic [IDW:0]        r_head;
  logic [IDW:0]        r_tail;
  logic [IDW-1:0]      r_fifo [NUM_TAGS];
  logic [NUM_TAGS-1:0] r_pending;
  logic [NUM_TAGS-1:0] r_done;
  logic [DATA_W-1:0]   r_data [NUM_TAGS];
  logic                r_err;

  logic                w_rsp_v;
  logic [IDW-1:0]      w_rsp_id;
  logic [DATA_W-1:0]   w_rsp_data;
  logic                w_empty;
  logic                w_full;
  logic [IDW-1:0]      w_head_id;
  logic                w_out_valid;
  logic                w_issue_ready;
  logic                w_push;
  logic                w_pop;
  logic                w_rsp_ok;
  logic                w_rsp_bad;

  assign w_rsp_v    = in_rsp[DATA_W+IDW];
  assign w_rsp_id   = in_rsp[DATA_W +: IDW];
  assign w_rsp_data = in_rsp[DATA_W-1:0];

  assign w_empty   = (r_head == r_tail);
  assign w_full    = (r_head[IDW-1:0] == r_tail[IDW-1:0]) && (r_head[IDW] != r_tail[IDW]);
  assign w_head_id = r_fifo[r_head[IDW-1:0]];

  // Registered state only: an ID popping this cycle still reads as pending,
  // so it cannot be re-issued until the following cycle.
  assign w_issue_ready = !w_full && !r_pending[issue_id];
  assign w_out_valid   = !w_empty && r_done[w_head_id];

  assign w_push = issue_valid && w_issue_ready;
  assign w_pop  = w_out_valid && out_ready;

  // A response for the popping head ID sees done already set and is dropped.
  assign w_rsp_ok  = w_rsp_v && r_pending[w_rsp_id] && !r_done[w_rsp_id];
  assign w_rsp_bad = w_rsp_v && !w_rsp_ok;

  assign issue_ready     = w_issue_ready;
  assign out_valid       = w_out_valid;
  assign out_id          = w_out_valid ? w_head_id : '0;
  assign out_data        = w_out_valid ? r_data[w_head_id] : '0;
  assign outstanding_cnt = r_tail - r_head;
  assign err_unexpected  = r_err;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_pending <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_rsp_bad;
      if (w_pop) begin
        r_head               <= r_head + PTR_ONE;
        r_pending[w_head_id] <= 1'b0;
        r_done[w_head_id]    <= 1'b0;
      end
      // Bits touched below never alias the popping head ID (see ready/ok terms).
      if (w_rsp_ok) begin
        r_done[w_rsp_id] <= 1'b1;
      end
      if (w_push) begin
        r_tail              <= r_tail + PTR_ONE;
        r_pending[issue_id] <= 1'b1;
      end
    end
  end

  // Payload storage: contents are only meaningful under pending/done, so no reset.
  always_ff @(posedge clk) begin
    if (!rst_b && w_push) begin
      r_fifo[r_tail[IDW-1:0]] <= issue_id;
    end
    if (!rst_b && w_rsp_ok) begin
      r_data[w_rsp_id] <= w_rsp_data;
    end
  end

endmodule

// File: tb/tb_rsp_reorder_buffer.sv
// tb/tb_rsp_reorder_buffer.sv - scoreboard bench for rsp_reorder_buffer
module tb_rsp_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        issue_valid;
  logic [2:0]  issue_id;
  logic        issue_ready;
  logic        rsp_v;
  logic [2:0]  rsp_id;
  logic [63:0] rsp_data;
  logic [67:0] in_rsp;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_id;
  logic [63:0] out_data;
  logic [3:0]  outstanding_cnt;
  logic        err_unexpected;

  assign in_rsp = {rsp_v, rsp_id, rsp_data};

  rsp_reorder_buffer #(.NUM_TAGS(8), .DATA_W(64)) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .issue_valid     (issue_valid),
    .issue_id        (issue_id),
    .issue_ready     (issue_ready),
    .in_rsp          (in_rsp),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_id          (out_id),
    .out_data        (out_data),
    .outstanding_cnt (outstanding_cnt),
    .err_unexpected  (err_unexpected)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: scoreboard queue of issued IDs in issue order,
  // per-ID pending/done flags and stored data.
  logic [2:0]  exp_q[$];
  bit   [7:0]  m_pend;
  bit   [7:0]  m_done;
  logic [63:0] m_data [8];
  bit          m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every cycle on the falling edge, then advances the
  // model to what the coming rising edge should produce.
  always @(negedge clk) begin
    bit         e_ready;
    bit         e_vld;
    bit         ok;
    logic [2:0] hid;
    if (rst_b === 1'b1) begin
      exp_q.delete();
      m_pend = '0;
      m_done = '0;
      m_err  = 1'b0;
    end else begin
      e_ready = (exp_q.size() < 8) && !m_pend[issue_id];
      e_vld   = (exp_q.size() != 0) && m_done[exp_q[0]];
      chk("issue_ready", issue_ready, e_ready);
      chk("outstanding_cnt", outstanding_cnt, exp_q.size());
      chk("err_unexpected", err_unexpected, m_err);
      chk("out_valid", out_valid, e_vld);
      if (e_vld) begin
        chk("out_id", out_id, exp_q[0]);
        chk("out_data", out_data, m_data[exp_q[0]]);
      end else begin
        chk("out_id_idle", out_id, 0);
        chk("out_data_idle", out_data, 0);
      end
      ok = rsp_v && m_pend[rsp_id] && !m_done[rsp_id];
      if (e_vld && out_ready) begin
        hid = exp_q.pop_front();
        m_pend[hid] = 1'b0;
        m_done[hid] = 1'b0;
      end
      if (ok) begin
        m_done[rsp_id] = 1'b1;
        m_data[rsp_id] = rsp_data;
      end
      if (issue_valid && e_ready) begin
        exp_q.push_back(issue_id);
        m_pend[issue_id] = 1'b1;
      end
      m_err = rsp_v && !ok;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [2:0] id);
    issue_valid = 1'b1;
    issue_id    = id;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_rsp(input logic [2:0] id, input logic [63:0] d);
    rsp_v    = 1'b1;
    rsp_id   = id;
    rsp_data = d;
    tick();
    rsp_v = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    out_ready   = 1'b1;
    issue_valid = 1'b0;
    while (exp_q.size() != 0 && cyc < 300) begin
      rsp_v = 1'b0;
      foreach (exp_q[i]) begin
        if (!m_done[exp_q[i]] && !rsp_v) begin
          rsp_v    = 1'b1;
          rsp_id   = exp_q[i];
          rsp_data = {$urandom, $urandom};
        end
      end
      tick();
      cyc++;
    end
    rsp_v = 1'b0;
    tick();
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    rst_b = 1'b1; issue_valid = 1'b0; issue_id = '0;
    rsp_v = 1'b0; rsp_id = '0; rsp_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst_b = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_cnt", outstanding_cnt, 0);

    // In order.
    out_ready = 1'b1;
    do_issue(3'd1); do_issue(3'd2);
    chk("io_cnt2", outstanding_cnt, 2);
    do_rsp(3'd1, 64'h11);
    chk("io_out1_id", out_id, 1);
    chk("io_out1_data", out_data, 64'h11);
    do_rsp(3'd2, 64'h22);
    chk("io_out2_id", out_id, 2);
    chk("io_out2_data", out_data, 64'h22);
    tick();
    chk("io_cnt0", outstanding_cnt, 0);

    // Reorder.
    do_issue(3'd3); do_issue(3'd5); do_issue(3'd6);
    do_rsp(3'd6, 64'hA6); chk("ro_wait6", out_valid, 0);
    do_rsp(3'd5, 64'hA5); chk("ro_wait5", out_valid, 0);
    do_rsp(3'd3, 64'hA3); chk("ro_first", out_id, 3);
    tick(); chk("ro_second", out_id, 5);
    tick(); chk("ro_third", out_id, 6);
    tick(); chk("ro_cnt0", outstanding_cnt, 0);

    // Full, then same-cycle pop/issue of the head ID.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) do_issue(3'(i));
    chk("full_cnt", outstanding_cnt, 8);
    chk("full_ready", issue_ready, 0);
    do_rsp(3'd0, 64'h100);
    out_ready = 1'b1; issue_valid = 1'b1; issue_id = 3'd0;
    #1 chk("full_samecyc_ready", issue_ready, 0);
    tick();
    out_ready = 1'b0;
    #1 chk("full_nextcyc_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    chk("full_reissue_cnt", outstanding_cnt, 8);
    drain();

    // Backpressure.
    out_ready = 1'b0;
    do_issue(3'd2);
    do_rsp(3'd2, 64'hBB);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_id", out_id, 2);
      chk("bp_data", out_data, 64'hBB);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_popped", outstanding_cnt, 0);

    // Unexpected responses.
    out_ready = 1'b0;
    do_rsp(3'd4, 64'h44);
    chk("err_never_issued", err_unexpected, 1);
    tick();
    chk("err_pulse_end", err_unexpected, 0);
    do_issue(3'd2);
    do_rsp(3'd2, 64'h22);
    do_rsp(3'd2, 64'h99);
    chk("err_dup", err_unexpected, 1);
    chk("err_dup_data_kept", out_data, 64'h22);
    tick();
    chk("err_dup_end", err_unexpected, 0);
    drain();

    // Reset mid-run.
    out_ready = 1'b0;
    do_issue(3'd1); do_issue(3'd2); do_issue(3'd3);
    do_rsp(3'd2, 64'h2);
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    chk("mrst_cnt", outstanding_cnt, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ready", issue_ready, 1);
    do_rsp(3'd1, 64'h1);
    chk("mrst_late_rsp_err", err_unexpected, 1);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_id    = 3'($urandom_range(0, 7));
      out_ready   = ($urandom_range(0, 3) != 0);
      rsp_v       = ($urandom_range(0, 1) != 0);
      if (exp_q.size() != 0 && $urandom_range(0, 4) != 0)
        rsp_id = exp_q[$urandom_range(0, exp_q.size() - 1)];
      else
        rsp_id = 3'($urandom_range(0, 7));
      rsp_data = {$urandom, $urandom};
      rst_b = ($urandom_range(0, 499) == 0);
      tick();
      rst_b = 1'b0;
    end
    rsp_v = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rsp_reorder_buffer.md
RSP_REORDER_BUFFER -- requirements
Module: rsp_reorder_buffer

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 8; number of distinct request IDs tracked (2^3 for 3-bit req_id).
REQ-002 SHALL have parameter DATA_W, default 64; response data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_b  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port issue_valid  input  1  upstream dispatcher presents a request ID being sent to the execution unit.
REQ-006 SHALL have port issue_id  input  3  ID of the issued request.
REQ-007 SHALL have port issue_ready  output  1  buffer accepts issue_id this cycle.
REQ-008 SHALL have port in_rsp  input  rsp_pkt_type  execution-unit response {rsp, rsp_id[2:0], rsp_data[63:0]}.
REQ-009 SHALL have port out_valid  output  1  in-order response available.
REQ-010 SHALL have port out_ready  input  1  downstream consumer accepts response.
REQ-011 SHALL have port out_id  output  3  ID of presented response.
REQ-012 SHALL have port out_data  output  DATA_W  data of presented response.
REQ-013 SHALL have port outstanding_cnt  output  4  issued-but-not-popped count, 0..8.
REQ-014 SHALL have port err_unexpected  output  1  one-cycle pulse, response dropped.

Function
REQ-015 SHALL keep an issue-order FIFO of IDs (depth NUM_TAGS, 3-bit pointers plus wrap bit), per-ID pending and done bits, and an 8 x DATA_W data array.
REQ-016 SHALL drive issue_ready = !full && !pending[issue_id]; uses registered state only, no credit for a same-cycle pop.
REQ-017 SHALL, on issue_valid && issue_ready, push issue_id at tail, set pending[issue_id], increment tail.
REQ-018 SHALL, on in_rsp.rsp with pending[rsp_id] && !done[rsp_id], write rsp_data to data[rsp_id] and set done[rsp_id].
REQ-019 SHALL, on in_rsp.rsp with !pending[rsp_id] or done[rsp_id], drop the response, leave state unchanged, and pulse err_unexpected the following cycle.
REQ-020 SHALL drive out_valid = !empty && done[head_id]; out_id = head_id; out_data = data[head_id]; out_id/out_data = 0 when out_valid is 0.
REQ-021 SHALL, on out_valid && out_ready, clear pending and done of head_id and increment head.
REQ-022 SHALL hold out_valid, out_id, out_data stable while out_valid && !out_ready.
REQ-023 SHALL have latency: response stored at edge N raises out_valid in cycle N+1 if its ID is at head; no combinational bypass from in_rsp to outputs.
REQ-024 SHALL let younger completed IDs wait until all older IDs pop (strict issue order).
REQ-025 SHALL handle simultaneous issue, response and pop in one cycle independently; outstanding_cnt net change = push - pop.
REQ-026 SHALL, when issue_id equals the ID popping that cycle, deassert issue_ready (pending still set); the ID is accepted next cycle.
REQ-027 SHALL, when a response arrives for the ID popping that cycle, treat it as unexpected (done already set) and drop it.
REQ-028 SHALL wrap head/tail modulo NUM_TAGS; full = pointers equal with wrap bits differing; empty = pointers and wrap bits equal.

Reset
REQ-029 SHALL, with rst_b high at a rising edge, clear head, tail, wrap bits, all pending and done bits, outstanding_cnt, err_unexpected; data array need not be cleared.
REQ-030 SHALL, after reset, present out_valid=0, out_id=0, out_data=0, issue_ready=1, outstanding_cnt=0.
REQ-031 SHALL, on reset mid-operation, discard all in-flight tracking; responses arriving after reset for pre-reset IDs SHALL pulse err_unexpected.

Verification
REQ-032 SHALL cover in-order: issue 1,2; rsp id1=0x11, id2=0x22; out_ready=1 -> out (1,0x11) then (2,0x22), cnt 2->0.
REQ-033 SHALL cover reorder: issue 3,5,6; rsp 6=0xA6, 5=0xA5, 3=0xA3 -> out_valid low until rsp 3 stored, then 3,5,6 back-to-back in order.
REQ-034 SHALL cover full: issue IDs 0..7 -> cnt=8, issue_ready=0; pop id0 with issue_valid id0 same cycle -> not accepted, accepted next cycle.
REQ-035 SHALL cover backpressure: head done, out_ready=0 for 5 cycles -> out_valid, out_id, out_data stable; pop on first out_ready=1.
REQ-036 SHALL cover errors: rsp for never-issued id4, then duplicate rsp for completed id2 -> err_unexpected pulses one cycle each, state unchanged.
REQ-037 SHALL cover reset mid-run: 3 outstanding, rst_b=1 one cycle -> cnt=0, out_valid=0, issue_ready=1; late rsp id1 -> err_unexpected.
